video_rom_sched: RTL and testbench

- Scheduler sharing one graphics-ROM read port between NREQ video fetch engines (sprite, fg tile, bg tile).
- Arbitration is keyed to the raster: during horizontal blank the sprite engine (requester 0) has absolute priority; during active video all requesters share round-robin.
- Also emits a per-line start pulse for the fetch engines and reports per-line fetch overruns.
- Sits between the video timing generator outputs (hbl, vbl) and the ROM/SDRAM controller.

---
 rtl/video_pkg.sv | 17 +
 rtl/video_rom_sched_rr_pick.sv | 39 +++
 rtl/video_rom_sched.sv | 143 ++++++++++++++
 tb/tb_video_rom_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared types and default constants for the graphics-ROM
// fetch scheduler.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam int REQ_SPRITE  = 0;
    localparam int NREQ_DEF    = 3;
    localparam int AW_DEF      = 20;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/video_rom_sched_rr_pick.sv
// rr_pick: combinational round-robin chooser with an optional
// absolute-priority override for the sprite requester.
module rr_pick
    import video_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    input  logic            prio0_en,
    output logic            valid,
    output logic [PW-1:0]   grant
);

    logic          found;
    logic [PW-1:0] idx;

    assign valid = |req;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (prio0_en && req[REQ_SPRITE]) begin
            grant = PW'(REQ_SPRITE);
        end else begin
            // Search starts one past the last rotating winner, wrapping mod NREQ.
            for (int j = 1; j <= NREQ; j++) begin
                idx = PW'((int'(rr_ptr) + j) % NREQ);
                if (!found && req[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/video_rom_sched.sv
// video_rom_sched: raster-aware arbiter sharing one graphics-ROM read
// port between the sprite, fg-tile and bg-tile fetch engines.
module video_rom_sched
    import video_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hbl,
    input  logic             vbl,
    output logic             line_start,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]  ack,
    output logic [DW-1:0]    dout,
    output logic             rom_req,
    output logic [AW-1:0]    rom_addr,
    input  logic             rom_ack,
    input  logic [DW-1:0]    rom_data,
    output logic [NREQ-1:0]  late,
    output logic             timeout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   g;
    logic [PW-1:0]   pick_g;
    logic            pick_valid;
    logic            prio0;
    logic            tmo;
    logic [CW-1:0]   cnt;
    logic            hbl_d;
    logic            vbl_d;
    logic [NREQ-1:0] late_set;
    logic [AW-1:0]   slot [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot[i] = addr[i*AW +: AW];
    end

    assign prio0 = hbl & req[REQ_SPRITE];

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .prio0_en (hbl),
        .valid    (pick_valid),
        .grant    (pick_g)
    );

    // Abort pulse shares the last ISSUE cycle; the ack follows next cycle.
    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (rom_ack) begin
                    state_nxt = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign timeout_err = tmo;

    always_comb begin
        late_set = '0;
        if (hbl_d && !hbl) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] || (state != IDLE && g == PW'(i)))
                    late_set[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= PW'(NREQ - 1);
            g          <= '0;
            cnt        <= '0;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
            dout       <= '0;
            ack        <= '0;
            late       <= '0;
            line_start <= 1'b0;
            hbl_d      <= hbl;
            vbl_d      <= vbl;
        end else begin
            state      <= state_nxt;
            ack        <= '0;
            line_start <= hbl & ~hbl_d;
            hbl_d      <= hbl;
            vbl_d      <= vbl;
            late       <= ((vbl && !vbl_d) ? '0 : late) | late_set;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        g        <= pick_g;
                        rom_req  <= 1'b1;
                        rom_addr <= slot[pick_g];
                        cnt      <= '0;
                        if (!prio0) rr_ptr <= pick_g;
                    end
                end
                ISSUE: begin
                    if (rom_ack) begin
                        dout    <= rom_data;
                        rom_req <= 1'b0;
                        ack     <= NREQ'(1) << g;
                    end else if (tmo) begin
                        dout    <= '0;
                        rom_req <= 1'b0;
                        ack     <= NREQ'(1) << g;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_video_rom_sched.sv
// tb_video_rom_sched: directed raster/arbitration scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_video_rom_sched;
    import video_pkg::*;

    localparam int NREQ    = 3;
    localparam int AW      = 20;
    localparam int DW      = 32;
    localparam int TIMEOUT = 64;
    localparam int M_FREE  = 0;
    localparam int M_ROM   = 1;
    localparam int M_ACK   = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              hbl;
    logic              vbl;
    logic              line_start;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     dout;
    logic              rom_req;
    logic [AW-1:0]     rom_addr;
    logic              rom_ack;
    logic [DW-1:0]     rom_data;
    logic [NREQ-1:0]   late;
    logic              timeout_err;

    always #5 clk = ~clk;

    video_rom_sched #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hbl(hbl), .vbl(vbl),
        .line_start(line_start), .req(req), .addr(addr), .ack(ack),
        .dout(dout), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data), .late(late),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int tcyc  = 0;
    int rom_mode = 0;
    int rom_k = 0;
    int rom_left = 0;
    bit rom_busy = 0;
    bit req_rand = 0;
    bit ras_rand = 0;

    task automatic cmp(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic rom_agent();
        rom_ack = 1'b0;
        if (rom_req) begin
            if (!rom_busy) begin
                rom_busy = 1'b1;
                if (rom_mode == 1) rom_left = rom_k;
                else if ($urandom_range(0, 24) == 0) rom_left = 1000;
                else rom_left = int'($urandom_range(0, 4));
            end
            if (rom_left == 0) begin
                rom_ack  = 1'b1;
                rom_data = $urandom;
                rom_busy = 1'b0;
            end else begin
                rom_left--;
            end
        end else begin
            rom_busy = 1'b0;
            if (rom_mode == 2 && $urandom_range(0, 7) == 0) begin
                rom_ack  = 1'b1;
                rom_data = $urandom;
            end
        end
    endtask

    task automatic req_agent();
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else addr[i*AW +: AW] = AW'($urandom);
                end else if ($urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                addr[i*AW +: AW] = AW'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tcyc++;
        if (rom_mode != 0) rom_agent();
        if (req_rand) req_agent();
        if (ras_rand) begin
            if ($urandom_range(0, 15) == 0) hbl = ~hbl;
            if ($urandom_range(0, 99) == 0) vbl = ~vbl;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_ack(input string name, output int idx, output int at);
        idx = -1;
        at  = tcyc;
        for (int n = 0; n < 100; n++) begin
            step();
            if (ack != '0) begin
                for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
                at = tcyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no ack within 100 cycles", name);
    endtask

    task automatic wait_rom_req(input string name);
        for (int n = 0; n < 10; n++) begin
            step();
            if (rom_req) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: rom_req not seen within 10 cycles", name);
    endtask

    // Reference model: transactions tracked by cycle stamps.
    function automatic int pick(input logic [NREQ-1:0] r, input int rr,
                                input logic h);
        if (h && r[0]) return 0;
        for (int j = 1; j <= NREQ; j++)
            if (r[(rr + j) % NREQ]) return (rr + j) % NREQ;
        return -1;
    endfunction

    bit              model_ok = 0;
    int              mcyc = 0;
    int              ph = M_FREE;
    int              mg = 0;
    int              t_iss = 0;
    int              m_rr = NREQ - 1;
    logic [NREQ-1:0] m_ack = '0;
    logic [NREQ-1:0] m_late = '0;
    logic [NREQ-1:0] setm;
    logic            m_rom_req = 0;
    logic            m_ls = 0;
    logic            m_to;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_dout = '0;
    logic            hb_p = 0;
    logic            vb_p = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            model_ok  = 1;
            ph        = M_FREE;
            m_rr      = NREQ - 1;
            m_ack     = '0;
            m_late    = '0;
            m_rom_req = 0;
            m_ls      = 0;
            m_addr    = '0;
            m_dout    = '0;
            hb_p      = hbl;
            vb_p      = vbl;
        end else if (model_ok) begin
            setm = '0;
            if (hb_p && !hbl)
                for (int i = 0; i < NREQ; i++)
                    if (req[i] || (ph != M_FREE && mg == i)) setm[i] = 1'b1;
            if (vbl && !vb_p) m_late = '0;
            m_late = m_late | setm;
            m_ls   = hbl && !hb_p;
            hb_p   = hbl;
            vb_p   = vbl;
            m_ack  = '0;
            if (ph == M_ACK) begin
                ph = M_FREE;
            end else if (ph == M_ROM) begin
                if (rom_ack) begin
                    m_dout = rom_data;
                    m_rom_req = 0;
                    m_ack[mg] = 1'b1;
                    ph = M_ACK;
                end else if (mcyc - t_iss == TIMEOUT - 1) begin
                    m_dout = '0;
                    m_rom_req = 0;
                    m_ack[mg] = 1'b1;
                    ph = M_ACK;
                end
            end else if (req != '0) begin
                mg = pick(req, m_rr, hbl);
                if (!(hbl && req[0])) m_rr = mg;
                t_iss     = mcyc + 1;
                m_rom_req = 1;
                m_addr    = addr[mg*AW +: AW];
                ph        = M_ROM;
            end
        end
        mcyc++;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            m_to = (ph == M_ROM) && (mcyc - t_iss == TIMEOUT - 1) && !rom_ack;
            cmp("rom_req", rom_req, m_rom_req);
            cmp("rom_addr", rom_addr, m_addr);
            cmp("ack", ack, m_ack);
            cmp("dout", dout, m_dout);
            cmp("late", late, m_late);
            cmp("line_start", line_start, m_ls);
            cmp("timeout_err", timeout_err, m_to);
        end
    end

    initial begin
        int idx, at, prev, n;
        reset_n = 0; hbl = 0; vbl = 0; req = '0; addr = '0;
        rom_ack = 0; rom_data = '0;
        step();
        step();
        cmp("rst_rom_req", rom_req, 0);
        cmp("rst_ack", ack, 0);
        cmp("rst_dout", dout, 0);
        cmp("rst_late", late, 0);
        cmp("rst_line_start", line_start, 0);
        cmp("rst_rom_addr", rom_addr, 0);
        reset_n = 1;

        // Single request, ROM answers k = 2 cycles after rom_req.
        req = 3'b001;
        addr[0 +: AW] = 20'h12345;
        step();
        cmp("single_rom_req", rom_req, 1);
        cmp("single_rom_addr", rom_addr, 20'h12345);
        step();
        cmp("single_early_ack", ack, 0);
        step();
        rom_ack = 1; rom_data = 32'hDEADBEEF;
        cmp("single_early_ack2", ack, 0);
        step();
        rom_ack = 0;
        cmp("single_ack", ack, 3'b001);
        cmp("single_dout", dout, 32'hDEADBEEF);
        req = '0;
        step();
        cmp("single_ack_once", ack, 0);

        // Round-robin then hblank priority then resumed rotation.
        do_reset();
        hbl = 0;
        req = 3'b111;
        addr = {20'h00300, 20'h00200, 20'h00100};
        rom_mode = 1; rom_k = 0; rom_busy = 0;
        prev = 0;
        for (int k = 0; k < 7; k++) begin
            wait_ack("rr_ack", idx, at);
            cmp("rr_order", idx, k % 3);
            if (k > 0) cmp("rr_period", at - prev, 3);
            prev = at;
        end
        hbl = 1;
        for (int k = 0; k < 3; k++) begin
            wait_ack("hbl_ack", idx, at);
            cmp("hbl_prio", idx, 0);
        end
        hbl = 0;
        wait_ack("resume_ack", idx, at);
        cmp("rr_resume", idx, 1);
        req = '0;

        // Timeout with a silent ROM.
        rom_mode = 0; rom_ack = 0;
        step();
        step();
        req = 3'b010;
        addr[AW +: AW] = 20'hABCDE;
        wait_rom_req("tmo_start");
        cmp("tmo_rom_addr", rom_addr, 20'hABCDE);
        n = 1;
        while (!timeout_err && n < 100) begin
            step();
            n++;
        end
        cmp("tmo_cycles", n, 64);
        cmp("tmo_rom_req_held", rom_req, 1);
        step();
        cmp("tmo_ack", ack, 3'b010);
        cmp("tmo_dout", dout, 0);
        cmp("tmo_err_once", timeout_err, 0);
        req = '0;
        step();
        cmp("tmo_idle_rom_req", rom_req, 0);
        cmp("tmo_idle_ack", ack, 0);

        // Raster flags.
        rom_mode = 1; rom_k = 0; rom_busy = 0;
        step();
        hbl = 1;
        step();
        cmp("line_start_pulse", line_start, 1);
        step();
        cmp("line_start_once", line_start, 0);
        req = 3'b100;
        addr[2*AW +: AW] = 20'h0F00D;
        hbl = 0;
        step();
        cmp("late_set", late[2], 1);
        req = '0;
        step();
        step();
        step();
        cmp("late_sticky", late[2], 1);
        vbl = 1;
        step();
        cmp("late_clear", late, 0);
        vbl = 0;
        step();

        // Reset while a transaction is in ISSUE.
        rom_mode = 0; rom_ack = 0;
        step();
        req = 3'b001;
        addr[0 +: AW] = 20'h54321;
        wait_rom_req("rst_mid_start");
        reset_n = 0;
        step();
        cmp("rst_mid_rom_req", rom_req, 0);
        cmp("rst_mid_ack", ack, 0);
        cmp("rst_mid_dout", dout, 0);
        cmp("rst_mid_rom_addr", rom_addr, 0);
        reset_n = 1;
        req = '0;
        step();
        rom_ack = 1; rom_data = 32'h5555AAAA;
        step();
        rom_ack = 0;
        for (int k = 0; k < 5; k++) begin
            cmp("rst_mid_no_ack", ack, 0);
            cmp("rst_mid_idle", rom_req, 0);
            step();
        end

        // Randomized traffic against the model.
        do_reset();
        rom_mode = 2; rom_busy = 0; req_rand = 1; ras_rand = 1;
        repeat (4000) step();
        req_rand = 0; ras_rand = 0; rom_mode = 0;
        req = '0; rom_ack = 0;
        repeat (80) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
